// File: rtl/beta_cache_refill_ctrl_if.sv
// rtl/beta_cache_refill_ctrl_if.sv - miss, memory and CAM-write signals of the Beta cache refill controller
interface beta_cache_refill_ctrl_if #(
    parameter int INDEX_W = 11,
    parameter int TAG_W   = 8,
    parameter int DATA_W  = 32
);
    localparam int AW = INDEX_W + TAG_W;

    logic              invalidate;
    logic              miss1_valid;
    logic [AW-1:0]     miss1_addr;
    logic              miss1_ack;
    logic              miss1_done;
    logic              miss2_valid;
    logic [AW-1:0]     miss2_addr;
    logic              miss2_ack;
    logic              miss2_done;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [AW-1:0]     mem_req_addr;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;
    logic              cam_we;
    logic [AW:0]       cam_write_addr;
    logic [DATA_W-1:0] cam_write_data;
    logic              busy;

    modport master (
        input  invalidate, miss1_valid, miss1_addr, miss2_valid, miss2_addr,
               mem_req_ready, mem_resp_valid, mem_resp_data,
        output miss1_ack, miss1_done, miss2_ack, miss2_done,
               mem_req_valid, mem_req_addr, cam_we, cam_write_addr, cam_write_data, busy
    );

    modport slave (
        output invalidate, miss1_valid, miss1_addr, miss2_valid, miss2_addr,
               mem_req_ready, mem_resp_valid, mem_resp_data,
        input  miss1_ack, miss1_done, miss2_ack, miss2_done,
               mem_req_valid, mem_req_addr, cam_we, cam_write_addr, cam_write_data, busy
    );
endinterface

// File: rtl/beta_cache_refill_ctrl.sv
// rtl/beta_cache_refill_ctrl.sv - miss handler and sole CAM writer for the 2-way Beta cache
module beta_cache_refill_ctrl #(
    parameter int INDEX_W        = 11,
    parameter int TAG_W          = 8,
    parameter int DATA_W         = 32,
    parameter bit FLUSH_ON_RESET = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    beta_cache_refill_ctrl_if.master bus
);
    localparam int AW   = INDEX_W + TAG_W;
    localparam int SETS = 2 ** INDEX_W;

    typedef enum logic [2:0] {S_FLUSH, S_IDLE, S_REQ, S_WAIT, S_FILL} state_t;

    state_t              state_q, state_d;
    logic [INDEX_W:0]    cnt_q, cnt_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                rr_q, rr_d;        // 0: port 1 wins the next tie
    logic                mark1_q, mark1_d;
    logic                mark2_q, mark2_d;
    logic                pend_inv_q, pend_inv_d;
    logic [SETS-1:0]     repl_q, repl_d;

    logic                pick1, pick2, same_addr, inv_now, fill_way;
    logic [INDEX_W-1:0]  fill_idx;

    assign fill_idx = addr_q[INDEX_W-1:0];
    assign fill_way = repl_q[fill_idx];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rr_d       = rr_q;
        mark1_d    = mark1_q;
        mark2_d    = mark2_q;
        pend_inv_d = pend_inv_q;
        repl_d     = repl_q;
        pick1      = 1'b0;
        pick2      = 1'b0;
        same_addr  = (bus.miss1_addr == bus.miss2_addr);
        inv_now    = pend_inv_q || bus.invalidate;

        bus.miss1_ack      = 1'b0;
        bus.miss2_ack      = 1'b0;
        bus.miss1_done     = 1'b0;
        bus.miss2_done     = 1'b0;
        bus.mem_req_valid  = 1'b0;
        bus.mem_req_addr   = '0;
        bus.cam_we         = 1'b0;
        bus.cam_write_addr = '0;
        bus.cam_write_data = '0;
        bus.busy           = 1'b0;

        if (!rst) begin
            bus.busy = (state_q != S_IDLE);
            case (state_q)
                S_FLUSH: begin
                    // Way lives in cnt[0] so both ways of an index are cleared back to back
                    bus.cam_we         = 1'b1;
                    bus.cam_write_addr = {cnt_q[0], {TAG_W{1'b0}}, cnt_q[INDEX_W:1]};
                    repl_d[cnt_q[INDEX_W:1]] = 1'b0;
                    if (bus.invalidate) begin
                        cnt_d = '0;
                    end else if (&cnt_q) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (inv_now) begin
                        state_d    = S_FLUSH;
                        cnt_d      = '0;
                        pend_inv_d = 1'b0;
                    end else if (bus.miss1_valid || bus.miss2_valid) begin
                        pick1 = bus.miss1_valid && (!bus.miss2_valid || !rr_q || same_addr);
                        pick2 = bus.miss2_valid && (!bus.miss1_valid || rr_q || same_addr);
                        addr_d        = pick1 ? bus.miss1_addr : bus.miss2_addr;
                        bus.miss1_ack = pick1;
                        bus.miss2_ack = pick2;
                        mark1_d       = pick1;
                        mark2_d       = pick2;
                        if (pick1 && !pick2)      rr_d = 1'b1;
                        else if (pick2 && !pick1) rr_d = 1'b0;
                        else                      rr_d = ~rr_q;
                        state_d = S_REQ;
                    end
                end
                S_REQ: begin
                    bus.mem_req_valid = 1'b1;
                    bus.mem_req_addr  = addr_q;
                    if (bus.invalidate)    pend_inv_d = 1'b1;
                    if (bus.mem_req_ready) state_d    = S_WAIT;
                end
                S_WAIT: begin
                    if (bus.invalidate) pend_inv_d = 1'b1;
                    if (bus.mem_resp_valid) begin
                        data_d  = bus.mem_resp_data;
                        state_d = S_FILL;
                    end
                end
                S_FILL: begin
                    // Requesters are released even when the write is dropped; they miss again after the sweep
                    bus.miss1_done = mark1_q;
                    bus.miss2_done = mark2_q;
                    mark1_d        = 1'b0;
                    mark2_d        = 1'b0;
                    if (inv_now) begin
                        state_d    = S_FLUSH;
                        cnt_d      = '0;
                        pend_inv_d = 1'b0;
                    end else begin
                        bus.cam_we         = 1'b1;
                        bus.cam_write_addr = {fill_way, addr_q};
                        bus.cam_write_data = data_q;
                        repl_d[fill_idx]   = ~fill_way;
                        state_d            = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FLUSH_ON_RESET ? S_FLUSH : S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            rr_q       <= 1'b0;
            mark1_q    <= 1'b0;
            mark2_q    <= 1'b0;
            pend_inv_q <= 1'b0;
            repl_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rr_q       <= rr_d;
            mark1_q    <= mark1_d;
            mark2_q    <= mark2_d;
            pend_inv_q <= pend_inv_d;
            repl_q     <= repl_d;
        end
    end
endmodule

// File: tb/tb_beta_cache_refill_ctrl.sv
// tb/tb_beta_cache_refill_ctrl.sv - directed self-checking bench for beta_cache_refill_ctrl
module tb_beta_cache_refill_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   fails  = 0;

    int          a1t, a2t, rqt, rqc, rqs, ct, cc, d1t, d2t;
    bit          chg;
    logic [18:0] ra;
    logic [19:0] ca;
    logic [31:0] cd;
    int          fn, fbad;
    bit          ffull;

    always #5 clk = ~clk;

    beta_cache_refill_ctrl_if #(.INDEX_W(11), .TAG_W(8), .DATA_W(32)) bus ();

    beta_cache_refill_ctrl #(.INDEX_W(11), .TAG_W(8), .DATA_W(32), .FLUSH_ON_RESET(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    task automatic clear_inputs();
        bus.invalidate     = 1'b0;
        bus.miss1_valid    = 1'b0;
        bus.miss1_addr     = '0;
        bus.miss2_valid    = 1'b0;
        bus.miss2_addr     = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
    endtask

    // Entered at posedge+1; samples from posedge+2 onward while cam_we is high.
    task automatic count_flush(output int n, output int bad, output bit full);
        bit [4095:0] seen;
        logic [11:0] idx;
        seen = '0; n = 0; bad = 0;
        #1;
        while (bus.cam_we && n < 5000) begin
            if (bus.cam_write_addr[18:11] != 8'h0 || bus.cam_write_data != 32'h0) bad++;
            idx = {bus.cam_write_addr[19], bus.cam_write_addr[10:0]};
            if (seen[idx]) bad++;
            seen[idx] = 1'b1;
            n++;
            @(posedge clk); #2;
        end
        full = &seen;
    endtask

    // Drives one miss transaction with a simple memory model and records event cycles (ack cycle = 0).
    task automatic serve(input bit v1, input bit v2, input logic [18:0] addr1, input logic [18:0] addr2,
                         input int rdly, input int gap, input logic [31:0] rdata, input bit inv_wait,
                         output int ack1_t, output int ack2_t, output int req_t, output int req_cyc,
                         output int reqs, output bit addr_chg, output logic [18:0] req_addr,
                         output int cam_t, output int cam_cnt, output logic [19:0] cam_addr,
                         output logic [31:0] cam_data, output int done1_t, output int done2_t);
        int t, hs_t;
        bit fin;
        ack1_t = -1; ack2_t = -1; req_t = -1; req_cyc = 0; reqs = 0; addr_chg = 0; req_addr = '0;
        cam_t = -1; cam_cnt = 0; cam_addr = '0; cam_data = '0; done1_t = -1; done2_t = -1;
        hs_t = -1; t = 0; fin = 0;
        @(posedge clk); #1;
        while (!fin && t < 80) begin
            bus.miss1_valid    = v1 && (ack1_t < 0);
            bus.miss1_addr     = addr1;
            bus.miss2_valid    = v2 && (ack2_t < 0);
            bus.miss2_addr     = addr2;
            bus.mem_req_ready  = (req_cyc >= rdly);
            bus.mem_resp_valid = (hs_t >= 0) && (t == hs_t + gap);
            bus.mem_resp_data  = bus.mem_resp_valid ? rdata : 32'h0;
            bus.invalidate     = inv_wait && (hs_t >= 0) && (t == hs_t + 1);
            #1;
            if (bus.miss1_ack) ack1_t = t;
            if (bus.miss2_ack) ack2_t = t;
            if (bus.mem_req_valid) begin
                if (req_t < 0) begin
                    req_t    = t;
                    req_addr = bus.mem_req_addr;
                end else if (bus.mem_req_addr != req_addr) begin
                    addr_chg = 1'b1;
                end
                req_cyc++;
                if (bus.mem_req_ready) begin
                    reqs++;
                    hs_t = t;
                end
            end
            if (bus.cam_we) begin
                cam_cnt++;
                cam_t    = t;
                cam_addr = bus.cam_write_addr;
                cam_data = bus.cam_write_data;
            end
            if (bus.miss1_done) done1_t = t;
            if (bus.miss2_done) done2_t = t;
            fin = (ack1_t >= 0 || ack2_t >= 0) && (ack1_t < 0 || done1_t >= 0) && (ack2_t < 0 || done2_t >= 0);
            if (!fin) begin
                @(posedge clk); #1;
                t++;
            end
        end
        clear_inputs();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.cam_we !== 1'b0) begin fails++; $display("FAIL reset_cam_we got %b want 0", bus.cam_we); end
        checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.mem_req_valid !== 1'b0) begin fails++; $display("FAIL reset_req got %b want 0", bus.mem_req_valid); end
        rst = 1'b0;
        count_flush(fn, fbad, ffull);
        checks++; if (fn !== 4096) begin fails++; $display("FAIL flush_count got %0d want 4096", fn); end
        checks++; if (fbad !== 0) begin fails++; $display("FAIL flush_tag_data_dup got %0d want 0", fbad); end
        checks++; if (ffull !== 1'b1) begin fails++; $display("FAIL flush_coverage got %b want 1", ffull); end
        checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL flush_busy_drop got %b want 0", bus.busy); end
    endtask

    task automatic test_fill();
        serve(1, 0, 19'h0A005, 19'h0, 0, 1, 32'hDEADBEEF, 0, a1t, a2t, rqt, rqc, rqs, chg, ra, ct, cc, ca, cd, d1t, d2t);
        checks++; if (a1t !== 0) begin fails++; $display("FAIL fill_ack1 got %0d want 0", a1t); end
        checks++; if (rqt !== 1) begin fails++; $display("FAIL fill_req_cycle got %0d want 1", rqt); end
        checks++; if (ra !== 19'h0A005) begin fails++; $display("FAIL fill_req_addr got %h want 0a005", ra); end
        checks++; if (ct !== 3) begin fails++; $display("FAIL fill_cam_cycle got %0d want 3", ct); end
        checks++; if (cc !== 1) begin fails++; $display("FAIL fill_cam_count got %0d want 1", cc); end
        checks++; if (ca !== 20'h0A005) begin fails++; $display("FAIL fill_cam_addr got %h want 0a005", ca); end
        checks++; if (cd !== 32'hDEADBEEF) begin fails++; $display("FAIL fill_cam_data got %h want deadbeef", cd); end
        checks++; if (d1t !== 3) begin fails++; $display("FAIL fill_done1 got %0d want 3", d1t); end
    endtask

    task automatic test_repl();
        serve(1, 0, 19'h0A805, 19'h0, 0, 1, 32'h11112222, 0, a1t, a2t, rqt, rqc, rqs, chg, ra, ct, cc, ca, cd, d1t, d2t);
        checks++; if (ca !== 20'h8A805) begin fails++; $display("FAIL repl_way1 got %h want 8a805", ca); end
        serve(1, 0, 19'h0B005, 19'h0, 0, 1, 32'h33334444, 0, a1t, a2t, rqt, rqc, rqs, chg, ra, ct, cc, ca, cd, d1t, d2t);
        checks++; if (ca !== 20'h0B005) begin fails++; $display("FAIL repl_way0 got %h want 0b005", ca); end
        checks++; if (cd !== 32'h33334444) begin fails++; $display("FAIL repl_data got %h want 33334444", cd); end
    endtask

    task automatic test_rr();
        int exp_port;
        serve(0, 1, 19'h0, 19'h00100, 0, 1, 32'h00000100, 0, a1t, a2t, rqt, rqc, rqs, chg, ra, ct, cc, ca, cd, d1t, d2t);
        checks++; if (a2t !== 0 || d2t !== 3) begin fails++; $display("FAIL rr_port2_only got ack %0d done %0d want 0 3", a2t, d2t); end
        for (int i = 0; i < 4; i++) begin
            exp_port = (i % 2 == 0) ? 1 : 2;
            serve(1, 1, 19'h00200, 19'h00300, 0, 1, 32'hA0A0A0A0, 0, a1t, a2t, rqt, rqc, rqs, chg, ra, ct, cc, ca, cd, d1t, d2t);
            checks++;
            if ((exp_port == 1 && (a1t !== 0 || a2t !== -1 || d1t !== 3)) ||
                (exp_port == 2 && (a2t !== 0 || a1t !== -1 || d2t !== 3))) begin
                fails++;
                $display("FAIL rr_order_%0d got ack1 %0d ack2 %0d want port %0d", i, a1t, a2t, exp_port);
            end
        end
        serve(1, 1, 19'h00400, 19'h00400, 0, 1, 32'h55AA55AA, 0, a1t, a2t, rqt, rqc, rqs, chg, ra, ct, cc, ca, cd, d1t, d2t);
        checks++; if (a1t !== 0 || a2t !== 0) begin fails++; $display("FAIL same_addr_acks got %0d %0d want 0 0", a1t, a2t); end
        checks++; if (rqs !== 1) begin fails++; $display("FAIL same_addr_reqs got %0d want 1", rqs); end
        checks++; if (d1t !== 3 || d2t !== 3) begin fails++; $display("FAIL same_addr_dones got %0d %0d want 3 3", d1t, d2t); end
    endtask

    task automatic test_stall();
        serve(1, 0, 19'h12345, 19'h0, 5, 1, 32'h0BADF00D, 0, a1t, a2t, rqt, rqc, rqs, chg, ra, ct, cc, ca, cd, d1t, d2t);
        checks++; if (rqc !== 6) begin fails++; $display("FAIL stall_req_cycles got %0d want 6", rqc); end
        checks++; if (chg !== 1'b0) begin fails++; $display("FAIL stall_addr_stable got %b want 0", chg); end
        checks++; if (rqs !== 1) begin fails++; $display("FAIL stall_req_count got %0d want 1", rqs); end
        checks++; if (ct !== 8) begin fails++; $display("FAIL stall_cam_cycle got %0d want 8", ct); end
        checks++; if (cd !== 32'h0BADF00D) begin fails++; $display("FAIL stall_cam_data got %h want 0badf00d", cd); end
    endtask

    task automatic test_inv_wait();
        serve(1, 0, 19'h00777, 19'h0, 0, 3, 32'hCAFEF00D, 1, a1t, a2t, rqt, rqc, rqs, chg, ra, ct, cc, ca, cd, d1t, d2t);
        checks++; if (cc !== 0) begin fails++; $display("FAIL inv_no_fill got %0d writes want 0", cc); end
        checks++; if (d1t !== 5) begin fails++; $display("FAIL inv_done1 got %0d want 5", d1t); end
        @(posedge clk); #1;
        count_flush(fn, fbad, ffull);
        checks++; if (fn !== 4096) begin fails++; $display("FAIL inv_flush_count got %0d want 4096", fn); end
        checks++; if (fbad !== 0 || ffull !== 1'b1) begin fails++; $display("FAIL inv_flush_content got bad %0d full %b want 0 1", fbad, ffull); end
    endtask

    task automatic test_rst_mid();
        int stray;
        @(posedge clk); #1;
        bus.miss1_valid = 1'b1; bus.miss1_addr = 19'h01234; bus.mem_req_ready = 1'b1;
        #1;
        checks++; if (bus.miss1_ack !== 1'b1) begin fails++; $display("FAIL rstmid_ack got %b want 1", bus.miss1_ack); end
        @(posedge clk); #1;
        bus.miss1_valid = 1'b0;
        #1;
        checks++; if (bus.mem_req_valid !== 1'b1) begin fails++; $display("FAIL rstmid_req got %b want 1", bus.mem_req_valid); end
        @(posedge clk); #1;
        bus.mem_req_ready = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'hFFFFFFFF;
        #1;
        checks++; if (bus.cam_we !== 1'b1 || bus.cam_write_data !== 32'h0 || bus.busy !== 1'b1) begin
            fails++; $display("FAIL rstmid_flush_start got we %b data %h busy %b want 1 0 1", bus.cam_we, bus.cam_write_data, bus.busy);
        end
        @(posedge clk); #1;
        bus.mem_resp_valid = 1'b0; bus.mem_resp_data = '0;
        count_flush(fn, fbad, ffull);
        checks++; if (fn !== 4095 || fbad !== 0) begin fails++; $display("FAIL rstmid_flush got n %0d bad %0d want 4095 0", fn, fbad); end
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.cam_we || bus.miss1_done || bus.miss2_done || bus.mem_req_valid) stray++;
            @(posedge clk); #2;
        end
        checks++; if (stray !== 0) begin fails++; $display("FAIL rstmid_quiet got %0d stray cycles want 0", stray); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_repl();
        test_rr();
        test_stall();
        test_inv_wait();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
